// File: rtl/pwm_meter_if.sv
// PWM link measurement bundle: the line into the meter and its results out.
interface pwm_meter_if #(
   parameter int CNT_W = 16
);
   logic             Invoer;
   logic [CNT_W-1:0] Hoog;
   logic [CNT_W-1:0] Periode;
   logic             Geldig;
   logic             Fout;

   // Meter side.
   modport slave (
      input  Invoer,
      output Hoog,
      output Periode,
      output Geldig,
      output Fout
   );

   // Source/consumer side.
   modport master (
      output Invoer,
      input  Hoog,
      input  Periode,
      input  Geldig,
      input  Fout
   );
endinterface

// File: rtl/pwm_meter.sv
// PWM period / high-time meter with loss-of-signal timeout.
//
// state | meaning
// ------+-------------------------------------------------------------
// WACHT | no valid reference rising edge yet; next rise only arms
// MEET  | measuring since the last rise; next rise reports the period
module pwm_meter #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 48000
) (
   input  logic        CLK,
   input  logic        Reset,
   pwm_meter_if.slave  bus
);

   typedef enum logic {WACHT = 1'b0, MEET = 1'b1} state_t;

   localparam logic [CNT_W-1:0] SAT     = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] hoog_cnt_q, hoog_cnt_d;
   logic [CNT_W-1:0] hoog_q, hoog_d;
   logic [CNT_W-1:0] periode_q, periode_d;
   logic             geldig_q, geldig_d;
   logic             fout_q, fout_d;
   logic             rise;
   logic             tmo;

   assign rise = s2_q & ~s3_q;
   // A rise in the same cycle as the terminal count takes priority.
   assign tmo  = (per_cnt_q == TMO_CNT) && !rise;

   // Two-flop synchroniser plus one delay stage for edge detection.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= bus.Invoer;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state_q <= WACHT;
      else       state_q <= state_d;
   end

   // Next-state: any rise arms/keeps measuring, a timeout drops the reference.
   always_comb begin
      state_d = state_q;
      if (rise)     state_d = MEET;
      else if (tmo) state_d = WACHT;
   end

   // Counter and result update; the rise cycle is the first high cycle of the new period.
   always_comb begin
      per_cnt_d  = (per_cnt_q == SAT) ? SAT : per_cnt_q + ONE;
      hoog_cnt_d = (s2_q && hoog_cnt_q != SAT) ? hoog_cnt_q + ONE : hoog_cnt_q;
      hoog_d     = hoog_q;
      periode_d  = periode_q;
      geldig_d   = 1'b0;
      fout_d     = fout_q;
      if (rise) begin
         per_cnt_d  = ONE;
         hoog_cnt_d = ONE;
         if (state_q == MEET) begin
            hoog_d    = hoog_cnt_q;
            periode_d = per_cnt_q;
            geldig_d  = 1'b1;
            fout_d    = 1'b0;
         end
      end else if (tmo) begin
         per_cnt_d  = '0;
         hoog_cnt_d = '0;
         hoog_d     = s2_q ? SAT : '0;
         periode_d  = TMO_CNT;
         geldig_d   = 1'b1;
         fout_d     = 1'b1;
      end
   end

   // Counter and output registers.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         per_cnt_q  <= '0;
         hoog_cnt_q <= '0;
         hoog_q     <= '0;
         periode_q  <= '0;
         geldig_q   <= 1'b0;
         fout_q     <= 1'b0;
      end else begin
         per_cnt_q  <= per_cnt_d;
         hoog_cnt_q <= hoog_cnt_d;
         hoog_q     <= hoog_d;
         periode_q  <= periode_d;
         geldig_q   <= geldig_d;
         fout_q     <= fout_d;
      end
   end

   assign bus.Hoog    = hoog_q;
   assign bus.Periode = periode_q;
   assign bus.Geldig  = geldig_q;
   assign bus.Fout    = fout_q;

endmodule
